// File: rtl/pipeline_buf_decode_if.sv
// Valid/ready handshake bundle between the fetch stage and the fetch/decode elastic buffer.
// The slave modport is the buffer's view; the master modport is the fetch/decode side.
interface pipeline_buf_decode_if #(
    parameter int PAYLOAD_WIDTH = 227,
    parameter int DEPTH         = 2
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic                     i_flush;
    logic                     i_valid;
    logic                     o_ready;
    logic [PAYLOAD_WIDTH-1:0] i_payload;
    logic                     o_valid;
    logic                     i_ready;
    logic [PAYLOAD_WIDTH-1:0] o_payload;
    logic [CNT_WIDTH-1:0]     o_count;

    modport master (
        output i_flush, i_valid, i_payload, i_ready,
        input  o_ready, o_valid, o_payload, o_count
    );

    modport slave (
        input  i_flush, i_valid, i_payload, i_ready,
        output o_ready, o_valid, o_payload, o_count
    );
endinterface

// File: rtl/pipeline_buf_decode.sv
// Elastic first-word-fall-through buffer between fetch and decode, with single-cycle flush.
// Define PIPE_BUF_BYPASS_EN to let a push into an empty buffer reach decode in the same cycle.
module pipeline_buf_decode #(
    parameter int PAYLOAD_WIDTH = 227,
    parameter int DEPTH         = 2
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    pipeline_buf_decode_if.slave  bus
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]     rd_ptr_q;
    logic [PTR_WIDTH-1:0]     wr_ptr_q;
    logic [CNT_WIDTH-1:0]     count_q;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_WIDTH'(DEPTH));

`ifdef PIPE_BUF_BYPASS_EN
    assign bypass = empty & bus.i_valid & ~bus.i_flush;
`else
    assign bypass = 1'b0;
`endif

    // Ready depends only on registered occupancy, so back-pressure never chains combinationally.
    assign bus.o_ready = ~full;
    assign bus.o_valid = ~empty | bypass;
    assign bus.o_count = count_q;

    always_comb begin
        bus.o_payload = '0;
        if (bypass) begin
            bus.o_payload = bus.i_payload;
        end else if (!empty) begin
            bus.o_payload = mem_q[rd_ptr_q];
        end
    end

    // A bypassed entry consumed directly by decode never touches storage.
    assign push = bus.i_valid & ~full & ~bus.i_flush & ~(bypass & bus.i_ready);
    assign pop  = ~empty & bus.i_ready & ~bus.i_flush;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.i_payload;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.i_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: doc/pipeline_buf_decode.md
Name: pipeline_buf_decode

Overview:
- Parametrised elastic successor to the fetch/decode pipeline register.
- Replaces the global stall wire with a valid/ready handshake on each side. Adds a DEPTH-entry first-word-fall-through buffer, so fetch keeps issuing for DEPTH cycles after decode back-pressures.
- Flush empties every buffered entry in one cycle.
- Sits between the fetch stage (upstream) and the decode stage (downstream). The payload is an opaque bus carrying {branch_pred_taken, btb_way, pc_target_addr_pred, instr, pc, pc_plus4}.

Parameters:
- PAYLOAD_WIDTH, 227, width of the opaque payload bus (1+2+64+32+64+64 by default).
- DEPTH, 2, number of buffer entries; a power of two, at least 2.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arst  input  1  asynchronous reset, active-high.
- i_flush  input  1  discard all buffered entries and any push in the same cycle.
- i_valid  input  1  upstream presents a valid payload.
- o_ready  output  1  buffer can accept a push this cycle.
- i_payload  input  PAYLOAD_WIDTH  upstream payload.
- o_valid  output  1  head entry is valid.
- i_ready  input  1  downstream accepts the head this cycle.
- o_payload  output  PAYLOAD_WIDTH  head entry payload; all-zero when o_valid=0.
- o_count  output  CNT_WIDTH  current number of entries (0..DEPTH).

Behaviour:
- Reset (i_arst=1, asynchronous):
  - read and write pointers = 0, count = 0.
  - o_valid=0, o_ready=1, o_payload=0, o_count=0.
  - Storage contents need no reset, but o_payload must read zero while empty.
- Push = i_valid & o_ready & ~i_flush. Pop = o_valid & i_ready & ~i_flush.
- o_ready = (count != DEPTH). It is a function of registered state only; no combinational path from i_ready to o_ready.
- o_valid = (count != 0). o_payload = storage[rd_ptr] when o_valid, else 0.
- Latency: a pushed entry appears on o_valid/o_payload on the cycle after the push edge, including when the buffer was empty.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push only: write storage[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle (possible only when 0<count<DEPTH): both pointers advance and count is unchanged.
- Full (count=DEPTH): o_ready=0; i_valid is ignored even if i_ready=1 in that cycle. Ready returns the cycle after a pop.
- Empty (count=0): i_ready is ignored; no pop occurs and no underflow.
- Flush (i_flush=1), next edge:
  - rd_ptr=wr_ptr=0, count=0.
  - Any coincident push or pop is cancelled.
  - o_valid=0 and o_payload=0 in the following cycle; o_ready=1.
- Flush has priority over every other operation. Reset has priority over flush.
- Reset asserted mid-operation drops all entries immediately (asynchronous), with no partial pointer update.
- o_payload must never expose stale data after a pop drains the last entry or after a flush.

Optional Feature:
- Macro: PIPE_BUF_BYPASS_EN.
- Defined: when count=0, i_valid=1 and i_flush=0:
  - o_valid=1 and o_payload=i_payload combinationally in the same cycle (zero latency).
  - If i_ready=1, the entry is consumed directly and not written to storage; count stays 0.
  - If i_ready=0, it is written as a normal push.
  - o_ready keeps its registered-only definition.
- Not defined: no bypass; minimum latency is 1 cycle as described above.

Test Plan:
- Reset: assert i_arst mid-cycle with count=2 -> immediately o_valid=0, o_count=0, o_ready=1, o_payload=0.
- Streaming: i_valid=1 and i_ready=1 held, payloads 0x1..0x8 on consecutive cycles -> o_payload shows 0x1..0x8 in order, one cycle later each; o_count stays at 1.
- Back-pressure: i_ready=0, push 0xA, 0xB, 0xC -> 0xA and 0xB accepted, o_count=2, o_ready=0, 0xC not taken. Raise i_ready for 2 cycles -> 0xA then 0xB popped; 0xC accepted in the cycle after the first pop.
- Flush: count=2, i_flush=1 with i_valid=1 and payload 0xD -> next cycle o_count=0, o_valid=0, o_payload=0, and 0xD never appears.
- Wrap: DEPTH=4, 10 push/pop cycles with alternating i_ready -> pointers wrap past 3, ordering is preserved, no loss or duplication, and o_count never exceeds 4.
- Bypass (PIPE_BUF_BYPASS_EN defined): empty buffer, i_valid=1, i_ready=1, payload 0x55 -> same-cycle o_valid=1, o_payload=0x55, o_count remains 0.
